uart_tx_arbiter: RTL and testbench

- Merges byte writes from the two core IO ports (A = older slot, B = younger slot of a dual-issue pair) into a single UART transmitter.
- Sits between the core's UART-mapped IO writes and the UART emitter.
- Buffers bytes in program order in a small FIFO, so simultaneous A/B writes never lose or reorder a byte.
- Supplies the busy status the core polls before writing.

---
 rtl/uart_tx_arbiter.sv | 86 ++++++++
 tb/tb_uart_tx_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Merges A/B UART byte writes from a dual-issue core into one transmitter.
// Bytes are queued in program order (A before B) in a circular FIFO.
module uart_tx_arbiter #(
   parameter int DEPTH = 8,
   parameter int DW    = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     a_wr,
   input  logic [DW-1:0]            a_data,
   input  logic                     b_wr,
   input  logic [DW-1:0]            b_data,
   output logic [DW-1:0]            tx_data,
   output logic                     tx_valid,
   input  logic                     tx_ready,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          overflow_q, overflow_d;
   logic          tx_valid_q, tx_valid_d;
   logic          busy_q, busy_d;

   logic          pop;
   logic [CW-1:0] free;
   logic          a_acc;
   logic          b_acc;
   logic [1:0]    n_acc;
   logic [AW-1:0] b_idx;

   always_comb begin
      pop   = tx_valid_q & tx_ready;
      // A slot released by this cycle's pop is immediately reusable.
      free  = CW'(DEPTH) - count_q + CW'(pop);
      a_acc = a_wr && (free != '0);
      b_acc = b_wr && (a_acc ? (free >= CW'(2)) : (free != '0));
      n_acc = {1'b0, a_acc} + {1'b0, b_acc};
      b_idx = a_acc ? (wr_ptr_q + AW'(1)) : wr_ptr_q;

      mem_d = mem_q;
      if (a_acc) mem_d[wr_ptr_q] = a_data;
      if (b_acc) mem_d[b_idx]    = b_data;

      wr_ptr_d   = wr_ptr_q + AW'(n_acc);
      rd_ptr_d   = rd_ptr_q + AW'(pop);
      count_d    = count_q + CW'(n_acc) - CW'(pop);
      overflow_d = overflow_q | (a_wr & ~a_acc) | (b_wr & ~b_acc);
      tx_valid_d = (count_d != '0);
      busy_d     = (count_d > CW'(DEPTH - 2));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         tx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         tx_valid_q <= tx_valid_d;
         busy_q     <= busy_d;
      end
   end

   assign tx_data  = mem_q[rd_ptr_q];
   assign tx_valid = tx_valid_q;
   assign busy     = busy_q;
   assign level    = count_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: a queue-based reference model predicts
// occupancy and emitted bytes; a negedge monitor checks every popped byte.
module tb_uart_tx_arbiter;

   localparam int DEPTH = 8;
   localparam int DW    = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          a_wr = 1'b0;
   logic [DW-1:0] a_data = '0;
   logic          b_wr = 1'b0;
   logic [DW-1:0] b_data = '0;
   logic [DW-1:0] tx_data;
   logic          tx_valid;
   logic          tx_ready = 1'b0;
   logic          busy;
   logic [$clog2(DEPTH):0] level;
   logic          overflow;

   logic [DW-1:0] exp_q [$];
   logic [DW-1:0] ref_q [$];
   logic          ovf_exp = 1'b0;
   int            total = 0;
   int            bad = 0;

   uart_tx_arbiter #(.DEPTH(DEPTH), .DW(DW)) dut (
      .clk(clk), .rst(rst),
      .a_wr(a_wr), .a_data(a_data),
      .b_wr(b_wr), .b_data(b_data),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .busy(busy), .level(level), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_state(input string tag);
      chk({tag, ".level"}, int'(level), ref_q.size());
      chk({tag, ".tx_valid"}, int'(tx_valid), int'(ref_q.size() != 0));
      chk({tag, ".busy"}, int'(busy), int'((DEPTH - ref_q.size()) < 2));
      chk({tag, ".overflow"}, int'(overflow), int'(ovf_exp));
   endtask

   // One clock: drive inputs, update the model for the coming edge, then check.
   task automatic cycle(input logic aw, input logic [DW-1:0] ad,
                        input logic bw, input logic [DW-1:0] bd,
                        input logic rdy, input string tag);
      int  free;
      bit  p;
      a_wr = aw; a_data = ad; b_wr = bw; b_data = bd; tx_ready = rdy;
      p    = (ref_q.size() != 0) && rdy;
      free = DEPTH - ref_q.size() + int'(p);
      if (p) void'(ref_q.pop_front());
      if (aw) begin
         if (free >= 1) begin ref_q.push_back(ad); exp_q.push_back(ad); free--; end
         else ovf_exp = 1'b1;
      end
      if (bw) begin
         if (free >= 1) begin ref_q.push_back(bd); exp_q.push_back(bd); free--; end
         else ovf_exp = 1'b1;
      end
      @(posedge clk); #1;
      a_wr = 1'b0; b_wr = 1'b0;
      check_state(tag);
   endtask

   task automatic do_reset();
      rst = 1'b1; a_wr = 1'b0; b_wr = 1'b0; tx_ready = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      ref_q.delete(); exp_q.delete(); ovf_exp = 1'b0;
      check_state("reset");
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 64 && ref_q.size() != 0; i++) cycle(1'b0, '0, 1'b0, '0, 1'b1, tag);
      chk({tag, ".drained"}, ref_q.size(), 0);
   endtask

   // Monitor: a byte is consumed at the next posedge whenever valid&ready here.
   always @(negedge clk) begin
      if (!rst && tx_valid && tx_ready) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL pop_unexpected: got 0x%02h expected no byte", tx_data);
         end else begin
            logic [DW-1:0] e;
            e = exp_q.pop_front();
            if (tx_data !== e) begin
               bad++;
               $display("FAIL tx_data: got 0x%02h expected 0x%02h", tx_data, e);
            end
         end
      end
   end

   initial begin
      int issued;
      @(posedge clk); #1;
      do_reset();

      // Single byte, one-cycle latency, then pop.
      cycle(1'b1, 8'h48, 1'b0, '0, 1'b1, "single");
      chk("single.data", int'(tx_data), 8'h48);
      cycle(1'b0, '0, 1'b0, '0, 1'b1, "single_pop");

      // Simultaneous A/B write keeps program order.
      cycle(1'b1, 8'h41, 1'b1, 8'h42, 1'b0, "dual");
      drain("dual_drain");

      // Fill to 7, then a dual write where only A fits.
      for (int i = 0; i < 7; i++) cycle(1'b1, DW'(i), 1'b0, '0, 1'b0, "fill7");
      cycle(1'b1, 8'h10, 1'b1, 8'h11, 1'b0, "ovf_dual");
      drain("ovf_drain");

      // Full FIFO with simultaneous pop and push: push accepted, no overflow.
      do_reset();
      for (int i = 0; i < 4; i++) cycle(1'b1, DW'(8'h20 + 2*i), 1'b1, DW'(8'h21 + 2*i), 1'b0, "fill8");
      cycle(1'b1, 8'h55, 1'b0, '0, 1'b1, "full_pushpop");
      drain("full_drain");

      // Wrap-around with busy honoured and random ready duty (~70%).
      do_reset();
      issued = 0;
      for (int i = 0; i < 2000 && issued < 20; i++) begin
         logic rdy;
         rdy = ($urandom_range(0, 9) < 7);
         if (!busy) begin
            cycle(1'b1, DW'($urandom), 1'b1, DW'($urandom), rdy, "wrap");
            issued++;
         end else begin
            cycle(1'b0, '0, 1'b0, '0, rdy, "wrap_wait");
         end
      end
      chk("wrap.issued", issued, 20);
      drain("wrap_drain");

      // Unconstrained random traffic, including drops.
      for (int i = 0; i < 300; i++)
         cycle(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)), DW'($urandom),
               1'($urandom_range(0, 1)), "rand");
      drain("rand_drain");

      // Reset in the middle of a drain with a write pending.
      do_reset();
      for (int i = 0; i < 3; i++) cycle(1'b1, DW'(8'h60 + i), 1'b0, '0, 1'b0, "pre_rst");
      rst = 1'b1; a_wr = 1'b1; a_data = 8'h99; tx_ready = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; a_wr = 1'b0; tx_ready = 1'b0;
      ref_q.delete(); exp_q.delete(); ovf_exp = 1'b0;
      check_state("mid_rst");
      cycle(1'b1, 8'h7A, 1'b0, '0, 1'b0, "post_rst");
      chk("post_rst.data", int'(tx_data), 8'h7A);
      drain("post_rst_drain");

      chk("leftover", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
